display_buffer_writer: RTL and testbench

Writer side of the packed character buffer that the VGA picture generator reads. Accepts calculator tokens (digits, operators, equals) over a valid/ready handshake and maintains a packed nibble buffer with append, backspace and clear. Exposes the buffer as `numbers`. Edits land in a working copy, which is committed to `numbers` only at the start of the vertical sync pulse, so a frame is never drawn from a half-edited buffer.

---
 rtl/display_buffer_writer.sv | 150 +++++++++++++++
 tb/tb_display_buffer_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/display_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : display_buffer_writer
// Brief    : Token-driven editor for the packed character buffer that the VGA
//            picture generator reads. Edits are committed on v-sync falling edge.
// Revision : 1.0  initial release
// ============================================================================
module display_buffer_writer #(
    parameter int MAX_INPUT = 60,
    parameter int CW        = $clog2(MAX_INPUT/4+1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tok_valid,
    output logic                 tok_ready,
    input  logic [1:0]           tok_cmd,
    input  logic [3:0]           tok_code,
    input  logic                 vga_v_sync,
    output logic [MAX_INPUT-1:0] numbers,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 err,
    output logic                 pending
);

    localparam int         c_S      = MAX_INPUT / 4;
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_APPLY  = 1'b1;
    localparam logic [1:0] c_APPEND = 2'b00;
    localparam logic [1:0] c_BKSP   = 2'b01;
    localparam logic [1:0] c_CLEAR  = 2'b10;
    localparam logic [3:0] c_BLANK  = 4'hF;

    logic [0:0]           r_state;
    logic [1:0]           r_cmd;
    logic [3:0]           r_code;
    logic [MAX_INPUT-1:0] r_work;
    logic [MAX_INPUT-1:0] r_numbers;
    logic [CW-1:0]        r_count;
    logic                 r_err;
    logic                 r_dirty;
    logic                 r_vs_q;

    logic [MAX_INPUT-1:0] w_work_nxt;
    logic [CW-1:0]        w_count_nxt;
    logic                 w_set_dirty;
    logic                 w_err_nxt;
    logic                 w_vs_fall;
    logic                 w_full;
    logic                 w_empty;

    assign w_full    = (r_count == CW'(c_S));
    assign w_empty   = (r_count == '0);
    assign w_vs_fall = r_vs_q & ~vga_v_sync;

    always_comb begin
        w_work_nxt  = r_work;
        w_count_nxt = r_count;
        w_set_dirty = 1'b0;
        w_err_nxt   = 1'b0;
        if (r_state == c_APPLY) begin
            case (r_cmd)
                c_APPEND: begin
                    if (!w_full && (r_code != c_BLANK)) begin
                        for (int i = 0; i < c_S; i++) begin
                            if (CW'(i) == r_count) begin
                                w_work_nxt[4*i +: 4] = r_code;
                            end
                        end
                        w_count_nxt = r_count + CW'(1);
                        w_set_dirty = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                c_BKSP: begin
                    // Backspace on an empty buffer is silently ignored.
                    if (!w_empty) begin
                        for (int i = 0; i < c_S; i++) begin
                            if (CW'(i) == (r_count - CW'(1))) begin
                                w_work_nxt[4*i +: 4] = c_BLANK;
                            end
                        end
                        w_count_nxt = r_count - CW'(1);
                        w_set_dirty = 1'b1;
                    end
                end
                c_CLEAR: begin
                    w_work_nxt  = '1;
                    w_count_nxt = '0;
                    w_set_dirty = 1'b1;
                end
                default: begin
                    w_err_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cmd     <= 2'b00;
            r_code    <= c_BLANK;
            r_work    <= '1;
            r_numbers <= '1;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_dirty   <= 1'b0;
            r_vs_q    <= 1'b1;
        end else begin
            r_vs_q  <= vga_v_sync;
            r_work  <= w_work_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
            // Commit samples the pre-edit working copy; a same-edge edit stays dirty.
            if (w_vs_fall && r_dirty) begin
                r_numbers <= r_work;
            end
            if (w_set_dirty) begin
                r_dirty <= 1'b1;
            end else if (w_vs_fall && r_dirty) begin
                r_dirty <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    if (tok_valid) begin
                        r_cmd   <= tok_cmd;
                        r_code  <= tok_code;
                        r_state <= c_APPLY;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign tok_ready = (r_state == c_IDLE);
    assign numbers   = r_numbers;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign err       = r_err;
    assign pending   = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_display_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_buffer_writer
// Brief    : Directed self-checking bench for display_buffer_writer.
// Revision : 1.0  initial release
// ============================================================================
module tb_display_buffer_writer;

    localparam logic [59:0] c_ALLF = 60'hFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_cmd;
    logic [3:0]  tok_code;
    logic        vga_v_sync;
    logic [59:0] numbers;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        err;
    logic        pending;

    int n_checks = 0;
    int n_pass   = 0;

    display_buffer_writer #(.MAX_INPUT(60)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_cmd    (tok_cmd),
        .tok_code   (tok_code),
        .vga_v_sync (vga_v_sync),
        .numbers    (numbers),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .err        (err),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request: handshake edge, then the apply edge; returns in IDLE.
    task automatic send(input logic [1:0] cmd, input logic [3:0] code);
        int n;
        tok_valid = 1'b1;
        tok_cmd   = cmd;
        tok_code  = code;
        n = 0;
        while (!tok_ready && n < 10) begin
            tick();
            n++;
        end
        check("send_ready", {63'd0, tok_ready}, 64'd1);
        tick();
        tok_valid = 1'b0;
        tick();
    endtask

    task automatic vs_pulse();
        vga_v_sync = 1'b0;
        tick();
        vga_v_sync = 1'b1;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        tok_valid  = 1'b0;
        tok_cmd    = 2'b00;
        tok_code   = 4'h0;
        vga_v_sync = 1'b1;
        #12;
        check("rst_numbers", {4'h0, numbers}, {4'h0, c_ALLF});
        check("rst_count",   {60'd0, count}, 64'd0);
        check("rst_empty",   {63'd0, empty}, 64'd1);
        check("rst_full",    {63'd0, full}, 64'd0);
        check("rst_ready",   {63'd0, tok_ready}, 64'd1);
        check("rst_pending", {63'd0, pending}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Append and commit
        send(2'b00, 4'h3);
        send(2'b00, 4'hA);
        send(2'b00, 4'h4);
        send(2'b00, 4'hE);
        tick();
        check("app_numbers_hold", {4'h0, numbers}, {4'h0, c_ALLF});
        check("app_pending",      {63'd0, pending}, 64'd1);
        vs_pulse();
        check("app_commit", {4'h0, numbers}, {4'h0, 60'hFFF_FFFF_FFFF_E4A3});
        check("app_count",  {60'd0, count}, 64'd4);
        check("app_clean",  {63'd0, pending}, 64'd0);

        // Fill and overflow
        send(2'b10, 4'h0);
        for (int i = 0; i < 15; i++) send(2'b00, 4'h7);
        check("fill_full",  {63'd0, full}, 64'd1);
        check("fill_count", {60'd0, count}, 64'd15);
        send(2'b00, 4'h1);
        check("ovf_err",   {63'd0, err}, 64'd1);
        tick();
        check("ovf_err_1cyc", {63'd0, err}, 64'd0);
        check("ovf_count",    {60'd0, count}, 64'd15);
        vs_pulse();
        check("ovf_buffer", {4'h0, numbers}, {4'h0, 60'h777_7777_7777_7777});

        // Backspace and clear
        send(2'b10, 4'h0);
        send(2'b00, 4'h1);
        send(2'b00, 4'h2);
        send(2'b01, 4'h0);
        check("bs_count", {60'd0, count}, 64'd1);
        vs_pulse();
        check("bs_slot1", {4'h0, numbers}, {4'h0, 60'hFFF_FFFF_FFFF_FFF1});
        send(2'b01, 4'h0);
        check("bs_err0", {63'd0, err}, 64'd0);
        send(2'b01, 4'h0);
        check("bs_empty_err", {63'd0, err}, 64'd0);
        check("bs_count0",    {60'd0, count}, 64'd0);
        send(2'b00, 4'hF);
        check("codeF_err",   {63'd0, err}, 64'd1);
        check("codeF_count", {60'd0, count}, 64'd0);
        send(2'b11, 4'h2);
        check("rsvd_err", {63'd0, err}, 64'd1);
        vs_pulse();
        check("bs_commit_clean", {63'd0, pending}, 64'd0);
        send(2'b10, 4'h0);
        check("clr_pending", {63'd0, pending}, 64'd1);
        vs_pulse();
        check("clr_commit", {4'h0, numbers}, {4'h0, c_ALLF});
        check("clr_clean",  {63'd0, pending}, 64'd0);

        // Commit collision: APPLY edge coincides with sync fall
        send(2'b00, 4'h9);
        tok_valid = 1'b1;
        tok_cmd   = 2'b00;
        tok_code  = 4'h5;
        tick();
        tok_valid  = 1'b0;
        vga_v_sync = 1'b0;
        tick();
        check("col_numbers", {4'h0, numbers}, {4'h0, 60'hFFF_FFFF_FFFF_FFF9});
        check("col_pending", {63'd0, pending}, 64'd1);
        check("col_count",   {60'd0, count}, 64'd2);
        vga_v_sync = 1'b1;
        tick();
        vs_pulse();
        check("col_commit", {4'h0, numbers}, {4'h0, 60'hFFF_FFFF_FFFF_FF59});
        check("col_clean",  {63'd0, pending}, 64'd0);

        // Handshake hold: valid held 4 cycles
        tok_valid = 1'b1;
        tok_cmd   = 2'b00;
        tok_code  = 4'h2;
        check("hold_rdy0", {63'd0, tok_ready}, 64'd1);
        tick();
        check("hold_rdy1", {63'd0, tok_ready}, 64'd0);
        tick();
        check("hold_rdy2", {63'd0, tok_ready}, 64'd1);
        tick();
        check("hold_rdy3", {63'd0, tok_ready}, 64'd0);
        tok_valid = 1'b0;
        tick();
        check("hold_count", {60'd0, count}, 64'd4);

        // Reset while in APPLY
        tok_valid = 1'b1;
        tok_cmd   = 2'b00;
        tok_code  = 4'h3;
        tick();
        tok_valid = 1'b0;
        check("mid_in_apply", {63'd0, tok_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_numbers", {4'h0, numbers}, {4'h0, c_ALLF});
        check("mid_count",   {60'd0, count}, 64'd0);
        check("mid_empty",   {63'd0, empty}, 64'd1);
        check("mid_ready",   {63'd0, tok_ready}, 64'd1);
        check("mid_pending", {63'd0, pending}, 64'd0);
        check("mid_err",     {63'd0, err}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mid_no_write", {60'd0, count}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
